target_spawner: RTL and testbench
=================================

// Module: target_spawner
// PURPOSE
//  Consumer end of the random target-select stream: samples the 0..9 target index on a periodic
//  spawn tick, lights that target, ages live targets and expires them, and scores player hits.
//  Sits between the random number generator and the display/LED driver; score output feeds
//  scoring logic and the generator's score input.
// PARAMETERS
//  NUM_TARGETS     10          number of target slots (index 0..NUM_TARGETS-1)
//  SPAWN_PERIOD    25000000    clock cycles between spawn ticks (>=2)
//  LIFETIME_TICKS  4           spawn ticks a target stays live before expiring (1..15)
// PORTS
//  clock         in   1            system clock, rising edge
//  reset         in   1            asynchronous, active-high
//  enable        in   1            1 = game running; 0 freezes tick counter, ages, spawns
//  ranNumTen     in   32           target index from generator, sampled on spawn tick
//  hit           in   NUM_TARGETS  player buttons, synchronous level; rising edge = press
//  active        out  NUM_TARGETS  live-target mask
//  score         out  32           count of successful hits, saturating
//  miss_count    out  32           expired targets + presses on unlit slots, saturating
//  spawn_pulse   out  1            1-cycle pulse when a target is spawned
// BEHAVIOUR
//  Reset: active=0, score=0, miss_count=0, spawn_pulse=0, tick counter=0, all ages=0, hit_prev=0.
//  Reset mid-game clears all state immediately (async); first tick SPAWN_PERIOD cycles after release.
//  Tick: counter runs 0..SPAWN_PERIOD-1 while enable=1; tick asserted in the cycle counter==SPAWN_PERIOD-1
//   (counter wraps to 0). enable=0 holds counter; hits still scored.
//  Press detect: press[i] = hit[i] & ~hit_prev[i]; hit_prev registered every cycle (even enable=0).
//  All decisions in a cycle use active/age values from the start of that cycle (pre-update).
//  Per cycle, for each slot i:
//   - press & active: clear slot, counts +1 to score (hit wins over same-cycle expiry).
//   - press & ~active: +1 to miss_count.
//   - tick & active & no press: age+1; if new age == LIFETIME_TICKS clear slot, +1 to miss_count.
//  Spawn on tick: sel=ranNumTen; if sel < NUM_TARGETS and slot sel inactive at start of cycle,
//   set active[sel], age=0, spawn_pulse=1 next cycle. sel out of range or slot already live:
//   no spawn, no pulse, no penalty. Spawn into slot pressed same cycle: press counts as miss, slot lit.
//  Counts: score += popcount(hit set); miss_count += popcount(expired)+popcount(wrong presses);
//   both saturate at 32'hFFFFFFFF, never wrap. Outputs registered; 1-cycle latency from press to score.
// STRUCTURE
//  Shared package (target_pkg): NUM_TARGETS, AGE_W=4, popcount function over NUM_TARGETS bits,
//   sat_add32 function.
//  Sub-module target_slot (x NUM_TARGETS via generate): holds active bit + age counter; inputs
//   tick, press, spawn; outputs active, hit_evt, expire_evt, wrong_evt. Top holds tick counter,
//   spawn select decode, popcount adders, saturating counters.
// TESTING  (bench: SPAWN_PERIOD=4, LIFETIME_TICKS=3)
//  1 reset, enable=1, ranNumTen=3 -> spawn_pulse at cycle 4 after release, active=10'b0000001000.
//  2 target 3 live, rising edge on hit[3] -> next cycle active[3]=0, score=1, miss_count=0.
//  3 target 3 live, no press, ranNumTen=12 -> after 3 ticks active[3] clears, miss_count=1, no new spawns.
//  4 press hit[5] (unlit) and hit[3] (lit) same cycle -> score+1, miss_count+1; holding hit high adds nothing.
//  5 press hit[3] in expiry tick cycle -> score+1, miss_count unchanged; ranNumTen=3 on tick with slot
//    live -> no pulse, age unaffected by attempted respawn.
//  6 force score=32'hFFFFFFFF, hit live target -> score stays FFFFFFFF; assert reset mid-period ->
//    all outputs 0 same cycle.

Source files
------------

// File: rtl/target_pkg.sv
// Shared constants and arithmetic helpers for the target spawner and its slots.
package target_pkg;

  localparam int unsigned NUM_TARGETS = 10;
  localparam int unsigned AGE_W       = 4;

  function automatic logic [31:0] popcount(input logic [NUM_TARGETS-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/target_slot.sv
// One target slot: live bit plus age in spawn ticks; reports hit, expiry and wrong-press events.
module target_slot
  import target_pkg::*;
#(
  parameter int unsigned LIFETIME_TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic press_i,
  input  logic spawn_i,
  output logic active_o,
  output logic hit_evt_o,
  output logic expire_evt_o,
  output logic wrong_evt_o
);

  logic             active_q, active_d;
  logic [AGE_W-1:0] age_q, age_d, age_inc;

  always_comb begin
    active_d     = active_q;
    age_d        = age_q;
    hit_evt_o    = 1'b0;
    expire_evt_o = 1'b0;
    wrong_evt_o  = 1'b0;
    age_inc      = age_q + AGE_W'(1);
    // A press takes priority over ageing, so a hit in the expiry tick still scores.
    if (press_i) begin
      if (active_q) begin
        active_d  = 1'b0;
        age_d     = '0;
        hit_evt_o = 1'b1;
      end else begin
        wrong_evt_o = 1'b1;
      end
    end else if (tick_i && active_q) begin
      if (age_inc == AGE_W'(LIFETIME_TICKS)) begin
        active_d     = 1'b0;
        age_d        = '0;
        expire_evt_o = 1'b1;
      end else begin
        age_d = age_inc;
      end
    end
    if (spawn_i && !active_q) begin
      active_d = 1'b1;
      age_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      age_q    <= '0;
    end else begin
      active_q <= active_d;
      age_q    <= age_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/target_spawner.sv
// Spawns targets from the random index stream on a periodic tick, ages them out and scores hits.
module target_spawner
  import target_pkg::*;
#(
  parameter int unsigned SPAWN_PERIOD   = 25000000,
  parameter int unsigned LIFETIME_TICKS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [31:0]            ranNumTen,
  input  logic [NUM_TARGETS-1:0] hit,
  output logic [NUM_TARGETS-1:0] active,
  output logic [31:0]            score,
  output logic [31:0]            miss_count,
  output logic                   spawn_pulse
);

  localparam int unsigned CntW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_TARGETS-1:0] hit_prev_q;
  logic [31:0]            score_q, score_d;
  logic [31:0]            miss_q, miss_d;
  logic                   pulse_q, pulse_d;

  logic                   tick;
  logic [NUM_TARGETS-1:0] press, spawn_sel, hit_evt, expire_evt, wrong_evt;

  assign tick  = enable && (cnt_q == CntW'(SPAWN_PERIOD - 1));
  assign press = hit & ~hit_prev_q;

  // Out-of-range indices match no slot, so they silently produce no spawn.
  always_comb begin
    spawn_sel = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      spawn_sel[i] = tick && (ranNumTen == 32'(i));
    end
  end

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_slot
    target_slot #(
      .LIFETIME_TICKS(LIFETIME_TICKS)
    ) u_slot (
      .clk_i       (clock),
      .rst_i       (reset),
      .tick_i      (tick),
      .press_i     (press[i]),
      .spawn_i     (spawn_sel[i]),
      .active_o    (active[i]),
      .hit_evt_o   (hit_evt[i]),
      .expire_evt_o(expire_evt[i]),
      .wrong_evt_o (wrong_evt[i])
    );
  end

  always_comb begin
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CntW'(1);
    end
    score_d = sat_add32(score_q, popcount(hit_evt));
    miss_d  = sat_add32(sat_add32(miss_q, popcount(expire_evt)), popcount(wrong_evt));
    pulse_d = |(spawn_sel & ~active);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      hit_prev_q <= '0;
      score_q    <= '0;
      miss_q     <= '0;
      pulse_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hit_prev_q <= hit;
      score_q    <= score_d;
      miss_q     <= miss_d;
      pulse_q    <= pulse_d;
    end
  end

  assign score       = score_q;
  assign miss_count  = miss_q;
  assign spawn_pulse = pulse_q;

endmodule

// File: tb/tb_target_spawner.sv
// Scoreboard bench for target_spawner: directed game scenarios followed by randomized play.
module tb_target_spawner;

  localparam int P = 4;
  localparam int L = 3;
  localparam int N = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [31:0]   ran;
  logic [N-1:0]  hit;
  logic [N-1:0]  active;
  logic [31:0]   score;
  logic [31:0]   miss_count;
  logic          spawn_pulse;

  always #5 clock = ~clock;

  target_spawner #(
    .SPAWN_PERIOD  (P),
    .LIFETIME_TICKS(L)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .ranNumTen  (ran),
    .hit        (hit),
    .active     (active),
    .score      (score),
    .miss_count (miss_count),
    .spawn_pulse(spawn_pulse)
  );

  typedef struct packed {
    logic [N-1:0] act;
    logic [31:0]  sc;
    logic [31:0]  ms;
    logic         pl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: game state as plain integers and flags.
  bit        m_live[N];
  int        m_age[N];
  longint    m_score, m_miss;
  int        m_cnt;
  bit [N-1:0] m_prev;
  bit        m_pulse;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_live[i] = 0;
      m_age[i]  = 0;
    end
    m_score = 0;
    m_miss  = 0;
    m_cnt   = 0;
    m_prev  = '0;
    m_pulse = 0;
  endfunction

  function automatic void model_step(bit en, logic [31:0] r, bit [N-1:0] h);
    bit tk;
    bit was[N];
    tk = en && (m_cnt == P - 1);
    if (en) m_cnt = (m_cnt + 1) % P;
    m_pulse = 0;
    for (int i = 0; i < N; i++) was[i] = m_live[i];
    for (int i = 0; i < N; i++) begin
      if (h[i] && !m_prev[i]) begin
        if (was[i]) begin
          m_live[i] = 0;
          m_score++;
        end else begin
          m_miss++;
        end
      end else if (tk && was[i]) begin
        m_age[i]++;
        if (m_age[i] == L) begin
          m_live[i] = 0;
          m_miss++;
        end
      end
    end
    if (tk && r < N && !was[r]) begin
      m_live[r] = 1;
      m_age[r]  = 0;
      m_pulse   = 1;
    end
    if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
    if (m_miss > 64'hFFFF_FFFF) m_miss = 64'hFFFF_FFFF;
    m_prev = h;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N; i++) e.act[i] = m_live[i];
    e.sc = m_score[31:0];
    e.ms = m_miss[31:0];
    e.pl = m_pulse;
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (active === e.act && score === e.sc && miss_count === e.ms && spawn_pulse === e.pl) begin
      passed++;
    end else begin
      $display("FAIL %s @%0t: got active=%h score=%h miss=%h pulse=%b, want active=%h score=%h miss=%h pulse=%b",
               name, $time, active, score, miss_count, spawn_pulse, e.act, e.sc, e.ms, e.pl);
    end
  endtask

  // Monitor: one expected entry per clock edge that the stimulus issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("scoreboard", e);
      end
    end
  end

  task automatic cyc(input bit en, input logic [31:0] r, input logic [N-1:0] h);
    @(negedge clock);
    reset  = 1'b0;
    enable = en;
    ran    = r;
    hit    = h;
    model_step(en, r, h);
    q.push_back(model_out());
  endtask

  task automatic rst_cycle();
    @(negedge clock);
    reset = 1'b1;
    hit   = '0;
    model_reset();
    #1;
    compare("async_reset", '0);
    q.push_back(model_out());
  endtask

  task automatic sat_cycle(input logic [N-1:0] h);
    @(negedge clock);
    force dut.score_q = 32'hFFFF_FFFF;
    enable  = 1'b1;
    ran     = 32'd3;
    hit     = h;
    m_score = 64'hFFFF_FFFF;
    model_step(1'b1, 32'd3, h);
    q.push_back(model_out());
    #4;
    release dut.score_q;
  endtask

  task automatic expect_now(input string name, input logic [N-1:0] a, input logic [31:0] s,
                            input logic [31:0] m, input logic p);
    exp_t e;
    @(posedge clock);
    #2;
    e.act = a;
    e.sc  = s;
    e.ms  = m;
    e.pl  = p;
    compare(name, e);
  endtask

  initial begin
    logic [N-1:0] hr;
    reset  = 1'b1;
    enable = 1'b0;
    ran    = '0;
    hit    = '0;
    model_reset();
    #1;
    compare("reset_state", '0);
    rst_cycle();
    rst_cycle();

    repeat (4) cyc(1'b1, 32'd3, '0);
    expect_now("first_spawn", 10'h008, 32'd0, 32'd0, 1'b1);
    cyc(1'b1, 32'd3, 10'h008);
    expect_now("hit_live", 10'h000, 32'd1, 32'd0, 1'b0);
    repeat (3) cyc(1'b1, 32'd3, '0);
    repeat (12) cyc(1'b1, 32'd12, '0);
    expect_now("expire", 10'h000, 32'd1, 32'd1, 1'b0);
    repeat (4) cyc(1'b1, 32'd3, '0);
    repeat (3) cyc(1'b1, 32'd12, 10'h028);
    expect_now("hit_and_wrong_held", 10'h000, 32'd2, 32'd2, 1'b0);
    repeat (9) cyc(1'b1, 32'd3, '0);
    expect_now("no_respawn_live", 10'h008, 32'd2, 32'd2, 1'b0);
    repeat (3) cyc(1'b1, 32'd3, '0);
    cyc(1'b1, 32'd3, 10'h008);
    expect_now("hit_on_expiry_tick", 10'h000, 32'd3, 32'd2, 1'b0);
    repeat (4) cyc(1'b1, 32'd3, '0);
    expect_now("respawn", 10'h008, 32'd3, 32'd2, 1'b1);
    sat_cycle(10'h008);
    expect_now("score_saturates", 10'h000, 32'hFFFF_FFFF, 32'd2, 1'b0);
    cyc(1'b1, 32'd3, '0);
    rst_cycle();

    hr = '0;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        rst_cycle();
        hr = '0;
      end
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) hr[b] = ~hr[b];
      end
      cyc(($urandom_range(0, 9) != 0), 32'($urandom_range(0, 14)), hr);
    end

    repeat (3) @(negedge clock);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drain: got %0d pending entries, want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
